// File: rtl/aemb_pkg.sv
// Shared AEMB interrupt constants: opcodes, exception encodings and FSM states.
// Used by aemb_intc and aemb_int_sync; the optional edge mode is AEMB_INT_EDGE_EN.
package aemb_pkg;

   localparam logic [5:0] OPC_BRU  = 6'o46;
   localparam logic [5:0] OPC_BRUI = 6'o56;
   localparam logic [5:0] OPC_BCC  = 6'o47;
   localparam logic [5:0] OPC_BCCI = 6'o57;
   localparam logic [5:0] OPC_RTD  = 6'o55;
   localparam logic [5:0] OPC_IMM  = 6'o54;

   localparam logic [4:0] RD_RTID  = 5'd17;

   typedef enum logic [1:0] {
      XCE_NONE = 2'o0,
      XCE_INT  = 2'o1
   } xce_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } int_state_t;

   // Instructions whose successor must not be split from them by an interrupt.
   function automatic logic is_nclr(input logic [5:0] opc);
      return (opc == OPC_BRU) || (opc == OPC_BRUI) || (opc == OPC_BCC) ||
             (opc == OPC_BCCI) || (opc == OPC_RTD) || (opc == OPC_IMM);
   endfunction

endpackage

// File: rtl/aemb_intc_if.sv
// Pipeline <-> interrupt controller bundle: decode-stage fields in, exception request out.
// master = pipeline side, slave = controller side.
interface aemb_intc_if #(
   parameter int NINT = 4,
   parameter int IW   = (NINT > 1) ? $clog2(NINT) : 1
);

   logic [5:0]      rOPC;
   logic [4:0]      rRD;
   logic            rBRA;
   logic            rDLY;
   logic            rMSR_IE;
   logic            xce_ack_i;
   logic [1:0]      rXCE;
   logic [IW-1:0]   rINTVEC;
   logic [NINT-1:0] rIPEND;
   logic            rISRV;

   modport master (
      output rOPC, rRD, rBRA, rDLY, rMSR_IE, xce_ack_i,
      input  rXCE, rINTVEC, rIPEND, rISRV
   );

   modport slave (
      input  rOPC, rRD, rBRA, rDLY, rMSR_IE, xce_ack_i,
      output rXCE, rINTVEC, rIPEND, rISRV
   );

endinterface

// File: rtl/aemb_int_sync.sv
// One interrupt line: SYNC-deep synchroniser, plus a sticky rising-edge latch when
// AEMB_INT_EDGE_EN is defined and EDGE_MODE=1; otherwise the pending bit is the synced level.
module aemb_int_sync #(
   parameter int SYNC      = 3,
   parameter bit EDGE_MODE = 1'b0
) (
   input  logic gclk,
   input  logic grst,
   input  logic gena,
   input  logic line_i,
   input  logic clr_i,
   output logic pend_o
);

   logic [SYNC-1:0] sync_q;
   logic            sync_out;

   always_ff @(posedge gclk) begin
      if (grst) begin
         sync_q <= '0;
      end else if (gena) begin
         sync_q <= {sync_q[SYNC-2:0], line_i};
      end
   end

   assign sync_out = sync_q[SYNC-1];

`ifdef AEMB_INT_EDGE_EN
   generate
      if (EDGE_MODE) begin : g_edge
         logic prev_q;
         logic pend_q;

         // A fresh edge beats a coincident clear so no event is lost.
         always_ff @(posedge gclk) begin
            if (grst) begin
               prev_q <= 1'b0;
               pend_q <= 1'b0;
            end else if (gena) begin
               prev_q <= sync_out;
               if (sync_out && !prev_q) begin
                  pend_q <= 1'b1;
               end else if (clr_i) begin
                  pend_q <= 1'b0;
               end
            end
         end

         assign pend_o = pend_q;
      end else begin : g_level
         wire unused_clr = clr_i;
         assign pend_o = sync_out;
      end
   endgenerate
`else
   wire unused_cfg = clr_i | EDGE_MODE;
   assign pend_o = sync_out;
`endif

endmodule

// File: rtl/aemb_intc.sv
// AEMB interrupt controller: synchronise lines, pick lowest pending, IDLE/REQ/SERV handshake.
// Edge-triggered channels exist only when AEMB_INT_EDGE_EN is defined.
module aemb_intc
   import aemb_pkg::*;
#(
   parameter int              NINT = 4,
   parameter int              SYNC = 3,
   parameter logic [NINT-1:0] EDGE = {NINT{1'b0}}
) (
   input  logic            gclk,
   input  logic            grst,
   input  logic            gena,
   input  logic [NINT-1:0] sys_int_i,
   aemb_intc_if.slave      bus
);

   localparam int IW = (NINT > 1) ? $clog2(NINT) : 1;

`ifdef AEMB_INT_EDGE_EN
   localparam logic [NINT-1:0] EDGE_EFF = EDGE;
`else
   localparam logic [NINT-1:0] EDGE_EFF = EDGE & {NINT{1'b0}};
`endif

   int_state_t      state_q;
   xce_t            rXCE_q;
   logic [IW-1:0]   rINTVEC_q;
   logic            rISRV_q;
   logic [NINT-1:0] ipend;
   logic [NINT-1:0] clr;
   logic            take;
   logic            rtid;

   function automatic logic [IW-1:0] lowest(input logic [NINT-1:0] p);
      logic [IW-1:0] r;
      r = '0;
      for (int i = NINT - 1; i >= 0; i--) begin
         if (p[i]) r = IW'(i);
      end
      return r;
   endfunction

   genvar g;
   generate
      for (g = 0; g < NINT; g++) begin : g_chan
         assign clr[g] = (state_q == ST_REQ) && bus.xce_ack_i && (rINTVEC_q == IW'(g));

         aemb_int_sync #(
            .SYNC      (SYNC),
            .EDGE_MODE (EDGE_EFF[g])
         ) u_sync (
            .gclk   (gclk),
            .grst   (grst),
            .gena   (gena),
            .line_i (sys_int_i[g]),
            .clr_i  (clr[g]),
            .pend_o (ipend[g])
         );
      end
   endgenerate

   // No interrupt between a taken branch and its delay slot, nor after IMM/branch/return.
   assign take = (|ipend) && bus.rMSR_IE && !is_nclr(bus.rOPC) && !(bus.rBRA && !bus.rDLY);
   assign rtid = (bus.rOPC == OPC_RTD) && (bus.rRD == RD_RTID);

   always_ff @(posedge gclk) begin
      if (grst) begin
         state_q   <= ST_IDLE;
         rXCE_q    <= XCE_NONE;
         rINTVEC_q <= '0;
         rISRV_q   <= 1'b0;
      end else if (gena) begin
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  state_q   <= ST_REQ;
                  rINTVEC_q <= lowest(ipend);
                  rXCE_q    <= XCE_INT;
               end
            end
            ST_REQ: begin
               // Once raised, only an ack or a vanished level line ends the request.
               if (bus.xce_ack_i) begin
                  state_q <= ST_SERV;
                  rXCE_q  <= XCE_NONE;
                  rISRV_q <= 1'b1;
               end else if (!EDGE_EFF[rINTVEC_q] && !ipend[rINTVEC_q]) begin
                  state_q <= ST_IDLE;
                  rXCE_q  <= XCE_NONE;
               end
            end
            ST_SERV: begin
               if (rtid) begin
                  state_q <= ST_IDLE;
                  rISRV_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               rXCE_q  <= XCE_NONE;
               rISRV_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rXCE    = rXCE_q;
   assign bus.rINTVEC = rINTVEC_q;
   assign bus.rIPEND  = ipend;
   assign bus.rISRV   = rISRV_q;

endmodule

// File: tb/tb_aemb_intc.sv
// Directed bench for aemb_intc (NINT=4, SYNC=3); edge section only with AEMB_INT_EDGE_EN.
module tb_aemb_intc;
   import aemb_pkg::*;

`ifdef AEMB_INT_EDGE_EN
   localparam logic [3:0] TB_EDGE = 4'b0001;
`else
   localparam logic [3:0] TB_EDGE = 4'b0000;
`endif

   logic       gclk;
   logic       grst;
   logic       gena;
   logic [3:0] sys_int;

   aemb_intc_if #(.NINT(4)) bus ();

   aemb_intc #(.NINT(4), .SYNC(3), .EDGE(TB_EDGE)) dut (
      .gclk      (gclk),
      .grst      (grst),
      .gena      (gena),
      .sys_int_i (sys_int),
      .bus       (bus)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   typedef struct {
      string      tag;
      logic [1:0] xce;
      logic [1:0] vec;
      logic       isrv;
      logic [3:0] ipend;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push(input string t, input logic [1:0] x, input logic [1:0] v,
                       input logic s, input logic [3:0] p);
      exp_t e;
      e.tag = t; e.xce = x; e.vec = v; e.isrv = s; e.ipend = p;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge gclk);
      #1;
   endtask

   task automatic chk();
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL scoreboard_empty observed=0 required=1");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (bus.rXCE === e.xce) else begin
         bad++; $error("FAIL %s.rXCE observed=%0d required=%0d", e.tag, bus.rXCE, e.xce);
      end
      total++;
      assert (bus.rINTVEC === e.vec) else begin
         bad++; $error("FAIL %s.rINTVEC observed=%0d required=%0d", e.tag, bus.rINTVEC, e.vec);
      end
      total++;
      assert (bus.rISRV === e.isrv) else begin
         bad++; $error("FAIL %s.rISRV observed=%0b required=%0b", e.tag, bus.rISRV, e.isrv);
      end
      total++;
      assert (bus.rIPEND === e.ipend) else begin
         bad++; $error("FAIL %s.rIPEND observed=%b required=%b", e.tag, bus.rIPEND, e.ipend);
      end
   endtask

   task automatic rtid_on();
      bus.rOPC = OPC_RTD;
      bus.rRD  = RD_RTID;
   endtask

   task automatic opc_clear();
      bus.rOPC = 6'o00;
      bus.rRD  = 5'd0;
   endtask

   initial begin
      grst = 1'b1; gena = 1'b1; sys_int = 4'b0000;
      bus.rOPC = 6'o00; bus.rRD = 5'd0; bus.rBRA = 1'b0; bus.rDLY = 1'b0;
      bus.rMSR_IE = 1'b0; bus.xce_ack_i = 1'b0;
      step(2);
      grst = 1'b0;
      push("reset", 2'o0, 2'd0, 1'b0, 4'b0000); chk();

      // Single level line 2: pending after SYNC, request one cycle later.
      sys_int = 4'b0100; bus.rMSR_IE = 1'b1;
      push("t1_sync", 2'o0, 2'd0, 1'b0, 4'b0100); step(3); chk();
      push("t1_req",  2'o1, 2'd2, 1'b0, 4'b0100); step(1); chk();
      bus.xce_ack_i = 1'b1; sys_int = 4'b0000;
      push("t1_ack",  2'o0, 2'd2, 1'b1, 4'b0100); step(1); chk();
      push("t1_ign",  2'o0, 2'd2, 1'b1, 4'b0100); step(1); chk();
      bus.xce_ack_i = 1'b0; rtid_on();
      push("t1_rtid", 2'o0, 2'd2, 1'b0, 4'b0000); step(1); chk();
      opc_clear();
      push("t1_idle", 2'o0, 2'd2, 1'b0, 4'b0000); step(1); chk();

      // Two lines at once: lowest wins, the other follows after return plus a gap cycle.
      sys_int = 4'b1010;
      push("t2_sync", 2'o0, 2'd2, 1'b0, 4'b1010); step(3); chk();
      push("t2_req1", 2'o1, 2'd1, 1'b0, 4'b1010); step(1); chk();
      bus.xce_ack_i = 1'b1; sys_int = 4'b1000;
      push("t2_ack1", 2'o0, 2'd1, 1'b1, 4'b1010); step(1); chk();
      bus.xce_ack_i = 1'b0;
      push("t2_serv", 2'o0, 2'd1, 1'b1, 4'b1000); step(2); chk();
      rtid_on();
      push("t2_gap",  2'o0, 2'd1, 1'b0, 4'b1000); step(1); chk();
      opc_clear();
      push("t2_req3", 2'o1, 2'd3, 1'b0, 4'b1000); step(1); chk();

      // Pipeline stall freezes everything, even an ack and a changing line.
      gena = 1'b0; bus.xce_ack_i = 1'b1; sys_int = 4'b0000;
      push("t2_frz",  2'o1, 2'd3, 1'b0, 4'b1000); step(5); chk();
      gena = 1'b1; bus.xce_ack_i = 1'b0;
      push("t2_drop", 2'o1, 2'd3, 1'b0, 4'b0000); step(3); chk();
      push("t2_wdrw", 2'o0, 2'd3, 1'b0, 4'b0000); step(1); chk();

      // IMM blocks the request until the opcode changes.
      bus.rOPC = OPC_IMM; sys_int = 4'b0001;
      push("t3_imm",  2'o0, 2'd3, 1'b0, 4'b0001); step(4); chk();
      opc_clear();
      push("t3_req",  2'o1, 2'd0, 1'b0, 4'b0001); step(1); chk();
      bus.xce_ack_i = 1'b1;
      push("t3_ack",  2'o0, 2'd0, 1'b1, 4'b0001); step(1); chk();
      bus.xce_ack_i = 1'b0; grst = 1'b1;
      push("t3_rst",  2'o0, 2'd0, 1'b0, 4'b0000); step(1); chk();
      grst = 1'b0; bus.rBRA = 1'b1; bus.rDLY = 1'b0;
      push("t3_bra",  2'o0, 2'd0, 1'b0, 4'b0001); step(4); chk();
      bus.rBRA = 1'b0;
      push("t3_req2", 2'o1, 2'd0, 1'b0, 4'b0001); step(1); chk();
      bus.rMSR_IE = 1'b0;
      push("t3_ie0",  2'o1, 2'd0, 1'b0, 4'b0001); step(2); chk();
      bus.rMSR_IE = 1'b1; bus.xce_ack_i = 1'b1; sys_int = 4'b0000;
      push("t3_ack2", 2'o0, 2'd0, 1'b1, 4'b0001); step(1); chk();
      bus.xce_ack_i = 1'b0;
      push("t3_serv", 2'o0, 2'd0, 1'b1, 4'b0000); step(2); chk();
      rtid_on();
      push("t3_rtid", 2'o0, 2'd0, 1'b0, 4'b0000); step(1); chk();
      opc_clear();

`ifdef AEMB_INT_EDGE_EN
      // One-cycle pulse is latched; a new edge landing on the ack cycle survives the clear.
      bus.rOPC = OPC_IMM; sys_int = 4'b0001;
      step(1);
      sys_int = 4'b0000;
      push("e_latch", 2'o0, 2'd0, 1'b0, 4'b0001); step(3); chk();
      push("e_hold",  2'o0, 2'd0, 1'b0, 4'b0001); step(2); chk();
      opc_clear();
      push("e_req",   2'o1, 2'd0, 1'b0, 4'b0001); step(1); chk();
      sys_int = 4'b0001;
      step(1);
      sys_int = 4'b0000;
      step(2);
      bus.xce_ack_i = 1'b1;
      push("e_setwin", 2'o0, 2'd0, 1'b1, 4'b0001); step(1); chk();
      bus.xce_ack_i = 1'b0; rtid_on();
      push("e_rtid",  2'o0, 2'd0, 1'b0, 4'b0001); step(1); chk();
      opc_clear();
      push("e_req2",  2'o1, 2'd0, 1'b0, 4'b0001); step(1); chk();
      bus.xce_ack_i = 1'b1;
      push("e_clear", 2'o0, 2'd0, 1'b1, 4'b0000); step(1); chk();
      bus.xce_ack_i = 1'b0;
`endif

      if (sb.size() != 0) begin
         total++; bad++;
         $error("FAIL scoreboard_left observed=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aemb_intc.md
AEMB_INTC -- requirements
Module: aemb_intc

Interface
REQ-001 SHALL provide parameter NINT, default 4, meaning number of interrupt channels (1..32).
REQ-002 SHALL provide parameter SYNC, default 3, meaning synchroniser depth in flops (>=2).
REQ-003 SHALL provide parameter EDGE, default {NINT{1'b0}}, meaning per-channel edge-trigger select (1=rising edge, 0=level).
REQ-004 SHALL define IW = max(1, clog2(NINT)), the vector width.
REQ-005 gclk  in  1  clock; all state updates on its rising edge.
REQ-006 grst  in  1  reset; synchronous, active-high.
REQ-007 gena  in  1  pipeline enable; when 0, all state holds.
REQ-008 sys_int_i  in  NINT  asynchronous interrupt lines.
REQ-009 rOPC  in  6  decode-stage opcode.
REQ-010 rRD  in  5  decode-stage destination field.
REQ-011 rBRA, rDLY  in  1 each  branch-taken and delay-slot flags.
REQ-012 rMSR_IE  in  1  global interrupt enable.
REQ-013 xce_ack_i  in  1  pipeline has taken the exception this cycle.
REQ-014 rXCE  out  2  exception request; 2'o0 none, 2'o1 interrupt.
REQ-015 rINTVEC  out  IW  index of the requested/serviced channel.
REQ-016 rIPEND  out  NINT  pending bits.
REQ-017 rISRV  out  1  high while an interrupt is in service.

Function
REQ-018 Each sys_int_i bit SHALL pass through SYNC flops, advancing only when gena=1; latency is SYNC enabled cycles.
REQ-019 Level channel: rIPEND[i] SHALL equal the synchronised line.
REQ-020 Edge channel: rIPEND[i] SHALL set on a synchronised 0->1 transition, and clear on xce_ack_i while rINTVEC==i; when set and clear coincide, set SHALL win.
REQ-021 FSM states SHALL be IDLE, REQ and SERV.
REQ-022 IDLE->REQ SHALL occur when |rIPEND & rMSR_IE & !fNCLR & !(rBRA & !rDLY); fNCLR = rOPC in {6'o46,6'o56,6'o47,6'o57,6'o55,6'o54}.
REQ-023 On entering REQ, rINTVEC SHALL latch the lowest-index pending channel and rXCE SHALL become 2'o1.
REQ-024 In REQ, rXCE SHALL stay 2'o1 until xce_ack_i; rMSR_IE falling SHALL NOT withdraw the request.
REQ-025 In REQ, if the latched channel is level and its rIPEND drops before ack, the FSM SHALL return to IDLE with rXCE=2'o0.
REQ-026 REQ->SERV on xce_ack_i: rXCE=2'o0 and rISRV=1 on the next cycle.
REQ-027 xce_ack_i outside REQ SHALL be ignored.
REQ-028 SERV->IDLE SHALL occur when rOPC==6'o55 & rRD==5'd17 (rtid); no nesting, so further requests wait in IDLE.
REQ-029 A return-from-interrupt and a new eligible interrupt SHALL need at least one IDLE cycle between them.

Reset
REQ-030 grst SHALL clear the synchronisers and rIPEND, set rXCE=2'o0, rINTVEC=0 and rISRV=0, and set FSM=IDLE; it SHALL take priority over gena.
REQ-031 A reset asserted in REQ or SERV SHALL abandon the request; no pending edge is retained.

Configuration
REQ-032 Macro AEMB_INT_EDGE_EN defined: the EDGE parameter SHALL be honoured per REQ-020.
REQ-033 AEMB_INT_EDGE_EN undefined: all channels SHALL be level, EDGE SHALL be ignored, and no edge-detect logic SHALL be built.

Structure
REQ-034 Shared package aemb_pkg SHALL hold the opcode constants (BRU, BCC, RTD, IMM), the XCE encodings, the rtid rRD value 17 and the FSM state encoding.
REQ-035 Per-channel synchroniser plus edge detect SHALL be sub-module aemb_int_sync, instantiated NINT times.

Verification
REQ-036 NINT=4, level: sys_int_i=4'b0100, rMSR_IE=1, rOPC=0 -> rXCE=2'o1 and rINTVEC=2 after SYNC+1 cycles; xce_ack_i -> rXCE=0 and rISRV=1; rOPC=6'o55 with rRD=17 -> rISRV=0.
REQ-037 sys_int_i=4'b1010 simultaneously -> rINTVEC=1; after rtid with line 1 low and line 3 still high -> rINTVEC=3.
REQ-038 Pending interrupt while rOPC=6'o54 (IMM), or rBRA=1 with rDLY=0 -> rXCE stays 0 that cycle and asserts once rOPC=0.
REQ-039 AEMB_INT_EDGE_EN, EDGE=4'b0001: a 1-cycle-per-SYNC pulse on line 0 -> rIPEND[0] latched; ack -> cleared; a new edge in the ack cycle -> rIPEND[0] stays 1.
REQ-040 gena=0 for 5 cycles during REQ -> all outputs frozen; grst in SERV -> next cycle all outputs 0 and FSM=IDLE.
